// File: rtl/step_sequencer.sv
// Phase/step timing generator: 4 phases of DIV clocks per step, one-hot step ring, run/halt/single control.
// Outputs decode registered state directly; halt/run take effect only at step boundaries.
module step_sequencer #(
   parameter int NUM_STEPS = 7,
   parameter int DIV       = 1,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run,
   input  logic                 halt,
   input  logic                 single,
   input  logic                 clr_step,
   output logic                 clk_en,
   output logic                 clk_set,
   output logic [NUM_STEPS-1:0] step,
   output logic                 halted,
   output logic [CNT_W-1:0]     instr_count
);

   localparam logic [1:0] S_HALTED = 2'd0;
   localparam logic [1:0] S_RUN    = 2'd1;
   localparam logic [1:0] S_SINGLE = 2'd2;

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0]        PRE_MAX    = PW'(DIV - 1);
   localparam logic [NUM_STEPS-1:0] FIRST_STEP = NUM_STEPS'(1);
   localparam logic [NUM_STEPS-1:0] RST_STEP   = {1'b1, {(NUM_STEPS-1){1'b0}}};

   logic [1:0]    state;
   logic [1:0]    ph;
   logic [PW-1:0] presc;
   logic          tick;
   logic          boundary;
   logic          live;

   assign tick     = (state != S_HALTED) && (presc == PRE_MAX);
   assign boundary = tick && (ph == 2'd3);

   // The reset step is a quiet slot: no strobes while it is active.
   assign live    = (state != S_HALTED) && !step[NUM_STEPS-1];
   assign clk_en  = live && (ph != 2'd0);
   assign clk_set = live && (ph == 2'd2);
   assign halted  = (state == S_HALTED);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= S_HALTED;
         ph          <= 2'd0;
         presc       <= '0;
         step        <= FIRST_STEP;
         instr_count <= '0;
      end else if (state == S_HALTED) begin
         ph    <= 2'd0;
         presc <= '0;
         if (!halt && run) begin
            state <= S_RUN;
         end else if (single) begin
            state <= S_SINGLE;
         end
      end else begin
         if (tick) begin
            presc <= '0;
            ph    <= ph + 2'd1;
         end else begin
            presc <= presc + PW'(1);
         end
         if (boundary) begin
            if (step[NUM_STEPS-1]) begin
               step        <= FIRST_STEP;
               instr_count <= instr_count + CNT_W'(1);
            end else if (clr_step) begin
               step <= RST_STEP;
            end else begin
               step <= {step[NUM_STEPS-2:0], step[NUM_STEPS-1]};
            end
            if ((state != S_RUN) || halt || !run) begin
               state <= S_HALTED;
            end
         end
      end
   end

endmodule
